// File: rtl/reaction_timer_pkg.sv
// reaction_timer_pkg
//   Shared types and constants for the reaction timer core.
//   rt_state_t  : measurement FSM states
//   bcd4_t      : four packed BCD digits, index 0 = ones of ms
//   BCD_BLANK   : digit code the display renders blank
//   BCD_MAX     : saturation value of the measurement (9999)
//   LFSR_SEED   : reset value of the delay LFSR
//   lfsr_next() : one step of the 16-bit Fibonacci LFSR (taps 16,14,13,11)
package reaction_timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    MEASURE,
    DONE,
    EARLY
  } rt_state_t;

  typedef logic [3:0][3:0] bcd4_t;

  localparam logic [3:0]  BCD_BLANK = 4'hF;
  localparam bcd4_t       BCD_MAX   = 16'h9999;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Shift left, feedback into bit 0. A non-zero seed never reaches zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

endpackage

// File: rtl/reaction_timer_bcd_counter4.sv
// bcd_counter4
//   Four-digit BCD up-counter that saturates at 9999.
//   clk_100MHz : clock
//   reset_n    : asynchronous active-low reset, clears count
//   clr        : synchronous clear to 0000 (has priority over inc)
//   inc        : advance by one with decimal carry; ignored at 9999
//   count      : current value, digit 0 least significant
//   at_max     : count is 9999
module bcd_counter4
  import reaction_timer_pkg::*;
(
  input  logic  clk_100MHz,
  input  logic  reset_n,
  input  logic  clr,
  input  logic  inc,
  output bcd4_t count,
  output logic  at_max
);

  bcd4_t count_nxt;
  logic  carry;

  assign at_max = (count == BCD_MAX);

  always_comb begin
    count_nxt = count;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (count[i] == 4'd9) begin
          count_nxt[i] = 4'd0;
        end else begin
          count_nxt[i] = count[i] + 4'd1;
          carry        = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/reaction_timer_core.sv
// reaction_timer_core
//   Measurement engine of the reaction timer: waits a pseudo-random delay,
//   lights the stimulus LED, then counts ticks in BCD until stop is pressed.
//   Optional feature macro: BEST_TIME_EN (keeps and displays the best time).
//   clk_100MHz   : system clock
//   reset_n      : asynchronous active-low reset (released synchronously)
//   btn_start    : raw start button
//   btn_stop     : raw stop/react button
//   show_best    : show best time in IDLE/DONE (BEST_TIME_EN only)
//   stim_led     : stimulus LED, high while measuring
//   k0..k3       : BCD display digits, k0 least significant, 4'hF = blank
//   result_valid : high in DONE
//   too_early    : high in EARLY
//
//   state   | meaning
//   IDLE    | after reset, waiting for start
//   WAIT    | random pre-stimulus delay running
//   MEASURE | LED on, counting ticks
//   DONE    | result (or 9999 timeout) on display
//   EARLY   | stop pressed before stimulus, display blank
module reaction_timer_core
  import reaction_timer_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int TICK_HZ      = 1000,
  parameter int MIN_DELAY_MS = 1000
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       show_best,
  output logic       stim_led,
  output logic [3:0] k0,
  output logic [3:0] k1,
  output logic [3:0] k2,
  output logic [3:0] k3,
  output logic       result_valid,
  output logic       too_early
);

  localparam int              TICK_DIV    = CLK_HZ / TICK_HZ;
  localparam int              TW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]   TICK_RELOAD = TW'(TICK_DIV - 1);
  localparam logic [15:0]     MIN_DELAY   = 16'(MIN_DELAY_MS);

  rt_state_t     state, state_nxt;
  logic [1:0]    rst_sync;
  logic          rst_n_i;
  logic [2:0]    start_sync, stop_sync;
  logic          start_pulse, stop_pulse;
  logic [TW-1:0] tick_cnt;
  logic          tick, tick_clr;
  logic [15:0]   lfsr;
  logic [15:0]   delay_cnt;
  logic          delay_load, delay_dec;
  logic          cnt_clr, cnt_inc, cnt_at_max, best_upd;
  bcd4_t         cnt_val, disp;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_i = rst_sync[1];

  // Two synchronizer flops plus one history flop for the rising edge.
  always_ff @(posedge clk_100MHz or negedge rst_n_i) begin
    if (!rst_n_i) begin
      start_sync <= '0;
      stop_sync  <= '0;
    end else begin
      start_sync <= {start_sync[1:0], btn_start};
      stop_sync  <= {stop_sync[1:0], btn_stop};
    end
  end
  assign start_pulse = start_sync[1] & ~start_sync[2];
  assign stop_pulse  = stop_sync[1] & ~stop_sync[2];

  // Reload on WAIT/MEASURE entry so the first tick there is a full period.
  always_ff @(posedge clk_100MHz or negedge rst_n_i) begin
    if (!rst_n_i)            tick_cnt <= TICK_RELOAD;
    else if (tick_clr||tick) tick_cnt <= TICK_RELOAD;
    else                     tick_cnt <= tick_cnt - TW'(1);
  end
  assign tick = (tick_cnt == '0);

  always_ff @(posedge clk_100MHz or negedge rst_n_i) begin
    if (!rst_n_i) lfsr <= LFSR_SEED;
    else          lfsr <= lfsr_next(lfsr);
  end

  always_ff @(posedge clk_100MHz or negedge rst_n_i) begin
    if (!rst_n_i)        delay_cnt <= '0;
    else if (delay_load) delay_cnt <= MIN_DELAY + {5'd0, lfsr[10:0]};
    else if (delay_dec)  delay_cnt <= delay_cnt - 16'd1;
  end

  always_ff @(posedge clk_100MHz or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    delay_load = 1'b0;
    delay_dec  = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    best_upd   = 1'b0;
    case (state)
      IDLE, DONE, EARLY: begin
        if (start_pulse) begin
          state_nxt  = WAIT;
          delay_load = 1'b1;
          cnt_clr    = 1'b1;
        end
      end
      WAIT: begin
        if (stop_pulse) begin
          state_nxt = EARLY;
        end else if (tick) begin
          // This tick takes the delay to zero.
          if (delay_cnt <= 16'd1) state_nxt = MEASURE;
          else                    delay_dec = 1'b1;
        end
      end
      MEASURE: begin
        // Stop beats a coincident tick, so that tick is never counted.
        if (stop_pulse) begin
          state_nxt = DONE;
          best_upd  = 1'b1;
        end else if (tick) begin
          if (cnt_at_max) state_nxt = DONE;
          else            cnt_inc   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tick_clr = (state_nxt != state) && ((state_nxt == WAIT) || (state_nxt == MEASURE));

  bcd_counter4 u_cnt (
    .clk_100MHz (clk_100MHz),
    .reset_n    (rst_n_i),
    .clr        (cnt_clr),
    .inc        (cnt_inc),
    .count      (cnt_val),
    .at_max     (cnt_at_max)
  );

`ifdef BEST_TIME_EN
  bcd4_t best;

  // Packed BCD orders the same as the decimal value, so a plain compare works.
  always_ff @(posedge clk_100MHz or negedge rst_n_i) begin
    if (!rst_n_i)                         best <= BCD_MAX;
    else if (best_upd && (cnt_val < best)) best <= cnt_val;
  end
`else
  logic unused_best;
  assign unused_best = show_best | best_upd;
`endif

  always_comb begin
    disp = cnt_val;
    if (state == EARLY) begin
      disp = {4{BCD_BLANK}};
    end
`ifdef BEST_TIME_EN
    else if (show_best && ((state == IDLE) || (state == DONE))) begin
      disp = best;
    end
`endif
  end

  assign k0           = disp[0];
  assign k1           = disp[1];
  assign k2           = disp[2];
  assign k3           = disp[3];
  assign stim_led     = (state == MEASURE);
  assign result_valid = (state == DONE);
  assign too_early    = (state == EARLY);

endmodule

// File: tb/tb_reaction_timer_core.sv
// tb_reaction_timer_core
//   Bench for reaction_timer_core with 2 clocks per tick so the 9999 timeout
//   stays short. Expected counts come from the timing rule: with stop raised
//   after N clock edges past the LED rising, the stop acts 3 edges later and
//   every tick strictly before that edge is counted, giving (N+2)/DIV ticks.
module tb_reaction_timer_core;

  localparam int CLK_HZ       = 200;
  localparam int TICK_HZ      = 100;
  localparam int MIN_DELAY_MS = 5;
  localparam int DIV          = CLK_HZ / TICK_HZ;
  localparam int WAIT_LIMIT   = (MIN_DELAY_MS + 2048) * DIV + 20;

  logic       clk_100MHz = 1'b0;
  logic       reset_n    = 1'b0;
  logic       btn_start  = 1'b0;
  logic       btn_stop   = 1'b0;
  logic       show_best  = 1'b0;
  logic       stim_led;
  logic [3:0] k0, k1, k2, k3;
  logic       result_valid;
  logic       too_early;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          n;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[7];

  reaction_timer_core #(
    .CLK_HZ       (CLK_HZ),
    .TICK_HZ      (TICK_HZ),
    .MIN_DELAY_MS (MIN_DELAY_MS)
  ) dut (
    .clk_100MHz   (clk_100MHz),
    .reset_n      (reset_n),
    .btn_start    (btn_start),
    .btn_stop     (btn_stop),
    .show_best    (show_best),
    .stim_led     (stim_led),
    .k0           (k0),
    .k1           (k1),
    .k2           (k2),
    .k3           (k3),
    .result_valid (result_valid),
    .too_early    (too_early)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  initial begin
    #1_200_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] digits();
    return {k3, k2, k1, k0};
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic press_start();
    @(negedge clk_100MHz);
    btn_start = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    btn_start = 1'b0;
  endtask

  task automatic wait_stim(output int c);
    c = 0;
    while (!stim_led && c < WAIT_LIMIT) begin
      @(negedge clk_100MHz);
      c++;
    end
    check("stim_rise", int'(stim_led), 1);
  endtask

  // Called at the first negedge with the LED lit.
  task automatic stop_after(input int n, input int hold, input bit mid_start);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_100MHz);
      if (mid_start && i == n / 2)     btn_start = 1'b1;
      if (mid_start && i == n / 2 + 3) btn_start = 1'b0;
    end
    btn_start = 1'b0;
    btn_stop  = 1'b1;
    repeat (hold) @(negedge clk_100MHz);
    btn_stop = 1'b0;
  endtask

  task automatic check_done(input string name, input logic [15:0] exp);
    check({name, "_digits"}, int'(digits()), int'(exp));
    check({name, "_valid"}, int'(result_valid), 1);
    check({name, "_led"}, int'(stim_led), 0);
  endtask

  initial begin
    int c;
    int n;
    int hold;
    bit ms;
    bit seen;
    logic [15:0] exp;

    tbl[0] = '{0,   16'h0001};
    tbl[1] = '{1,   16'h0001};
    tbl[2] = '{17,  16'h0009};
    tbl[3] = '{18,  16'h0010};
    tbl[4] = '{396, 16'h0199};
    tbl[5] = '{398, 16'h0200};
    tbl[6] = '{472, 16'h0237};

    repeat (3) @(negedge clk_100MHz);
    check("reset_led", int'(stim_led), 0);
    check("reset_digits", int'(digits()), 0);
    check("reset_valid", int'(result_valid), 0);
    check("reset_early", int'(too_early), 0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk_100MHz);
    check("idle_led", int'(stim_led), 0);
    check("idle_digits", int'(digits()), 0);
    check("idle_valid", int'(result_valid), 0);
    check("idle_early", int'(too_early), 0);

    for (int i = 0; i < 7; i++) begin
      press_start();
      wait_stim(c);
      if (i == 0)
        check("delay_range",
              int'(c >= MIN_DELAY_MS * DIV && c <= (MIN_DELAY_MS + 2047) * DIV), 1);
      stop_after(tbl[i].n, 3, 1'b0);
      check_done("tbl", tbl[i].exp);
      repeat (2) @(negedge clk_100MHz);
    end

    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 40)) @(negedge clk_100MHz);
      press_start();
      check("restart_clear", int'(digits()), 0);
      wait_stim(c);
      n    = $urandom_range(20, 600);
      hold = $urandom_range(3, 20);
      ms   = 1'($urandom_range(0, 1));
      stop_after(n, hold, ms);
      exp = to_bcd((n + 2) / DIV);
      check_done("rand", exp);
      btn_stop = 1'b1;
      repeat (4) @(negedge clk_100MHz);
      btn_stop = 1'b0;
      repeat (2) @(negedge clk_100MHz);
      check("stop_in_done", int'(digits()), int'(exp));
    end

    press_start();
    btn_stop = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    btn_stop = 1'b0;
    check("early_flag", int'(too_early), 1);
    check("early_digits", int'(digits()), 16'hFFFF);
    check("early_valid", int'(result_valid), 0);
    seen = 1'b0;
    repeat (200) begin
      @(negedge clk_100MHz);
      if (stim_led) seen = 1'b1;
    end
    check("early_no_led", int'(seen), 0);
    press_start();
    check("early_restart_flag", int'(too_early), 0);
    check("early_restart_digits", int'(digits()), 0);

    wait_stim(c);
    repeat (84) @(negedge clk_100MHz);
    check("pre_reset_count", int'(digits()), 16'h0042);
    reset_n = 1'b0;
    #1;
    check("async_reset_led", int'(stim_led), 0);
    check("async_reset_digits", int'(digits()), 0);
    check("async_reset_valid", int'(result_valid), 0);
    repeat (3) @(negedge clk_100MHz);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_100MHz);

    show_best = 1'b1;
    #1;
`ifdef BEST_TIME_EN
    check("idle_show_best", int'(digits()), 16'h9999);
`else
    check("idle_show_best", int'(digits()), 16'h0000);
`endif
    show_best = 1'b0;

    press_start();
    wait_stim(c);
    stop_after(998, 3, 1'b0);
    check_done("best_500", 16'h0500);
    press_start();
    wait_stim(c);
    stop_after(598, 3, 1'b0);
    check_done("best_300", 16'h0300);
    press_start();
    wait_stim(c);
    stop_after(798, 3, 1'b0);
    check_done("best_400", 16'h0400);
    show_best = 1'b1;
    #1;
`ifdef BEST_TIME_EN
    check("done_show_best", int'(digits()), 16'h0300);
`else
    check("done_show_best", int'(digits()), 16'h0400);
`endif

    press_start();
    check("wait_show_live", int'(digits()), 0);
    show_best = 1'b0;
    wait_stim(c);
    c = 0;
    while (!result_valid && c < 10000 * DIV + 100) begin
      @(negedge clk_100MHz);
      c++;
    end
    check("timeout_clocks", c, 10000 * DIV);
    check_done("timeout", 16'h9999);
    show_best = 1'b1;
    #1;
`ifdef BEST_TIME_EN
    check("timeout_keeps_best", int'(digits()), 16'h0300);
`else
    check("timeout_keeps_best", int'(digits()), 16'h9999);
`endif
    show_best = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
